// File: rtl/uart_wr_ctrl_if.sv
// Bus between uart_wr_ctrl and its neighbours (uart_rx, SDRAM FIFO controller).
// Ports: rx_data/rx_flag and rd_fifo_num flow into the controller;
//        wr_req/wr_data, read_valid, busy and ovf flow out of it.
// master: the surrounding system (drives rx and fill level). slave: the controller.
`timescale 1ns/1ps
interface uart_wr_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_flag;
  logic [9:0]  rd_fifo_num;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        read_valid;
  logic        busy;
  logic        ovf;

  modport master (
    output rx_data, rx_flag, rd_fifo_num,
    input  wr_req, wr_data, read_valid, busy, ovf
  );

  modport slave (
    input  rx_data, rx_flag, rd_fifo_num,
    output wr_req, wr_data, read_valid, busy, ovf
  );
endinterface

// File: rtl/uart_wr_ctrl.sv
// Packs UART bytes into 16-bit words and writes one fixed-length SDRAM burst, padding short bursts.
// Latency: wr_req one cycle after the completing rx_flag; read_valid WAIT_CYC+1 cycles after last write.
// Backpressure: none upstream; bytes arriving while the burst is closing (pad/wait/read) are dropped and ovf sets.
// Ports: clk_50m, rst_n (async, active-low) plus bus (slave modport of uart_wr_ctrl_if).
// Option: define UART_WR_BYTE_PACK_EN to pack two bytes per word (little-endian); otherwise one byte per word.
`timescale 1ns/1ps
module uart_wr_ctrl #(
  parameter int BURST_NUM    = 10,
  parameter int IDLE_TIMEOUT = 52080,
  parameter int WAIT_CYC     = 750
) (
  input  logic           clk_50m,
  input  logic           rst_n,
  uart_wr_ctrl_if.slave  bus
);

  localparam logic [9:0]  BURST_W   = 10'(BURST_NUM);
  localparam logic [16:0] IDLE_LAST = 17'(IDLE_TIMEOUT - 1);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_PAD,
    S_WAIT,
    S_READ
  } state_t;

  state_t      state, state_nxt;
  logic [9:0]  word_cnt, word_cnt_nxt;
  logic [16:0] idle_cnt, idle_cnt_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        half_valid, half_valid_nxt;
  logic [7:0]  held, held_nxt;
  logic        wr_req, wr_req_nxt;
  logic [15:0] wr_data, wr_data_nxt;
  logic        read_valid, read_valid_nxt;
  logic        ovf, ovf_nxt;
  logic        take_byte;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      word_cnt   <= '0;
      idle_cnt   <= '0;
      wait_cnt   <= '0;
      half_valid <= 1'b0;
      held       <= '0;
      wr_req     <= 1'b0;
      wr_data    <= '0;
      read_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_cnt   <= word_cnt_nxt;
      idle_cnt   <= idle_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      half_valid <= half_valid_nxt;
      held       <= held_nxt;
      wr_req     <= wr_req_nxt;
      wr_data    <= wr_data_nxt;
      read_valid <= read_valid_nxt;
      ovf        <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    word_cnt_nxt   = word_cnt;
    idle_cnt_nxt   = idle_cnt;
    wait_cnt_nxt   = wait_cnt;
    half_valid_nxt = half_valid;
    held_nxt       = held;
    wr_req_nxt     = 1'b0;
    wr_data_nxt    = wr_data;
    read_valid_nxt = read_valid;
    ovf_nxt        = ovf;
    take_byte      = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.rx_flag) begin
          take_byte    = 1'b1;
          idle_cnt_nxt = '0;
          state_nxt    = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // The final word's wr_req is on the wire this cycle; a byte landing now
        // would overfill the burst, so it is dropped.
        if (word_cnt == BURST_W) begin
          state_nxt = S_WAIT;
        end else if (bus.rx_flag) begin
          // A byte on the expiry cycle beats the timeout.
          take_byte    = 1'b1;
          idle_cnt_nxt = '0;
        end else if (idle_cnt == IDLE_LAST) begin
          idle_cnt_nxt = '0;
          state_nxt    = S_PAD;
        end else begin
          idle_cnt_nxt = idle_cnt + 17'd1;
        end
      end

      S_PAD: begin
        if (word_cnt == BURST_W) begin
          state_nxt = S_WAIT;
        end else begin
          // A pending half word goes out first, zero-extended; then zeros.
          wr_req_nxt     = 1'b1;
          wr_data_nxt    = half_valid ? {8'h00, held} : 16'h0000;
          half_valid_nxt = 1'b0;
          word_cnt_nxt   = word_cnt + 10'd1;
        end
      end

      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          wait_cnt_nxt   = '0;
          read_valid_nxt = 1'b1;
          state_nxt      = S_READ;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end

      S_READ: begin
        if (bus.rd_fifo_num >= BURST_W) begin
          read_valid_nxt = 1'b0;
          word_cnt_nxt   = '0;
          idle_cnt_nxt   = '0;
          state_nxt      = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    if (take_byte) begin
`ifdef UART_WR_BYTE_PACK_EN
      if (half_valid) begin
        wr_req_nxt     = 1'b1;
        wr_data_nxt    = {bus.rx_data, held};
        half_valid_nxt = 1'b0;
        word_cnt_nxt   = word_cnt + 10'd1;
      end else begin
        held_nxt       = bus.rx_data;
        half_valid_nxt = 1'b1;
      end
`else
      wr_req_nxt   = 1'b1;
      wr_data_nxt  = {8'h00, bus.rx_data};
      word_cnt_nxt = word_cnt + 10'd1;
`endif
    end

    // Any strobe not consumed above was a dropped byte.
    if (bus.rx_flag && !take_byte) begin
      ovf_nxt = 1'b1;
    end
  end

  assign bus.wr_req     = wr_req;
  assign bus.wr_data    = wr_data;
  assign bus.read_valid = read_valid;
  assign bus.ovf        = ovf;
  assign bus.busy       = (state == S_PAD) || (state == S_WAIT) || (state == S_READ);

endmodule

// File: tb/tb_uart_wr_ctrl.sv
// Directed bench for uart_wr_ctrl with shortened timeout/wait parameters.
// Works in both builds; expected words follow UART_WR_BYTE_PACK_EN.
`timescale 1ns/1ps
module tb_uart_wr_ctrl;
  localparam int BN  = 10;
  localparam int IT  = 200;
  localparam int WC  = 20;
  localparam int GAP = 30;
`ifdef UART_WR_BYTE_PACK_EN
  localparam int PK = 1;
`else
  localparam int PK = 0;
`endif

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_50m = ~clk_50m;

  uart_wr_ctrl_if bus();

  uart_wr_ctrl #(.BURST_NUM(BN), .IDLE_TIMEOUT(IT), .WAIT_CYC(WC)) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  logic [15:0] wr_q[$];
  int          wr_t[$];
  int          flag_t[$];
  int          rv_rise = -1;
  logic        rv_prev = 1'b0;
  logic [7:0]  stim[$];
  logic [15:0] exp_w[BN];

  always @(negedge clk_50m) begin
    if (bus.wr_req) begin
      wr_q.push_back(bus.wr_data);
      wr_t.push_back(cyc);
    end
    if (bus.read_valid && !rv_prev) rv_rise = cyc;
    rv_prev = bus.read_valid;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_t.delete();
    flag_t.delete();
    rv_rise = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_flag = 1'b1;
    flag_t.push_back(cyc);
    tick(1);
    bus.rx_flag = 1'b0;
  endtask

  task automatic send_all();
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i]);
      if (i != stim.size() - 1) tick(GAP);
    end
  endtask

  task automatic wait_rv(input string tag);
    int k;
    k = 0;
    while (!bus.read_valid && k < IT + WC + BN + 100) begin
      tick(1);
      k++;
    end
    check({tag, "_rv_arrive"}, bus.read_valid, 1);
  endtask

  task automatic end_read(input string tag);
    bus.rd_fifo_num = 10'(BN - 1);
    tick(2);
    check({tag, "_rv_hold"}, bus.read_valid, 1);
    check({tag, "_busy_read"}, bus.busy, 1);
    bus.rd_fifo_num = 10'(BN);
    tick(1);
    check({tag, "_rv_drop"}, bus.read_valid, 0);
    check({tag, "_busy_idle"}, bus.busy, 0);
    bus.rd_fifo_num = '0;
  endtask

  // n_data: words completed from real bytes; the rest are pad writes.
  task automatic check_burst(input string tag, input int n_data);
    int lastf;
    check({tag, "_cnt"}, wr_q.size(), BN);
    for (int i = 0; i < BN; i++) begin
      if (i < wr_q.size()) check($sformatf("%s_w%0d", tag, i), wr_q[i], exp_w[i]);
    end
    if (wr_q.size() == BN) begin
      lastf = flag_t[flag_t.size() - 1];
      check({tag, "_lat"}, wr_t[0], flag_t[PK] + 1);
      if (n_data < BN) begin
        check({tag, "_pad_start"}, wr_t[n_data], lastf + IT + 2);
        check({tag, "_pad_end"}, wr_t[BN - 1], lastf + IT + 2 + BN - 1 - n_data);
      end
      check({tag, "_rv_time"}, rv_rise, wr_t[BN - 1] + WC + 1);
    end
  endtask

  task automatic load_full();
    stim.delete();
    for (int i = 0; i < BN * (1 + PK); i++) stim.push_back(8'(i + 1));
    for (int i = 0; i < BN; i++) begin
`ifdef UART_WR_BYTE_PACK_EN
      exp_w[i] = {8'(2 * i + 2), 8'(2 * i + 1)};
`else
      exp_w[i] = 16'(i + 1);
`endif
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    check({tag, "_wr_req"}, bus.wr_req, 0);
    check({tag, "_wr_data"}, bus.wr_data, 0);
    check({tag, "_rv"}, bus.read_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ovf"}, bus.ovf, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data     = '0;
    bus.rx_flag     = 1'b0;
    bus.rd_fifo_num = '0;
    tick(2);
    chk_outs_zero("rst");
    rst_n = 1'b1;
    tick(2);

    // Full burst, no padding.
    clear_log();
    load_full();
    send_all();
    tick(3);
    check("full_busy_wait", bus.busy, 1);
    wait_rv("full");
    end_read("full");
    check_burst("full", BN);
    check("full_ovf", bus.ovf, 0);

    // Short burst flushed by the idle timeout.
    clear_log();
    stim.delete();
    for (int i = 0; i < BN; i++) exp_w[i] = 16'h0000;
`ifdef UART_WR_BYTE_PACK_EN
    stim.push_back(8'h11); stim.push_back(8'h22); stim.push_back(8'h33);
    exp_w[0] = 16'h2211;
    exp_w[1] = 16'h0033;
`else
    stim.push_back(8'hA1); stim.push_back(8'hA2); stim.push_back(8'hA3); stim.push_back(8'hA4);
    exp_w[0] = 16'h00A1; exp_w[1] = 16'h00A2; exp_w[2] = 16'h00A3; exp_w[3] = 16'h00A4;
`endif
    send_all();
    wait_rv("pad");
    end_read("pad");
    check_burst("pad", PK ? 1 : 4);
    check("pad_ovf", bus.ovf, 0);

    // Byte during S_WAIT is dropped and ovf sticks.
    clear_log();
    load_full();
    send_all();
    tick(3);
    check("ovf_busy", bus.busy, 1);
    send_byte(8'h55);
    tick(2);
    check("ovf_set", bus.ovf, 1);
    wait_rv("ovf");
    end_read("ovf");
    check_burst("ovf", BN);
    tick(5);
    check("ovf_sticky", bus.ovf, 1);

    // Reset mid-burst: outputs clear at once, nothing flushed afterwards.
    clear_log();
    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(8'(8'h40 + i));
    send_all();
    tick(5);
    #3 rst_n = 1'b0;
    #1 chk_outs_zero("midrst");
    tick(1);
    rst_n = 1'b1;
    clear_log();
    tick(IT + WC + BN + 50);
    check("midrst_no_wr", wr_q.size(), 0);
    check("midrst_idle_busy", bus.busy, 0);
    clear_log();
    load_full();
    send_all();
    wait_rv("post");
    end_read("post");
    check_burst("post", BN);

    // Byte on the exact expiry cycle beats the timeout and restarts idle_cnt.
    clear_log();
    for (int i = 0; i < BN; i++) exp_w[i] = 16'h0000;
    send_byte(8'h66);
    tick(IT - 1);
    send_byte(8'h77);
    check("edge_wr_req", bus.wr_req, 1);
    check("edge_busy", bus.busy, 0);
`ifdef UART_WR_BYTE_PACK_EN
    check("edge_wr_data", bus.wr_data, 16'h7766);
    exp_w[0] = 16'h7766;
`else
    check("edge_wr_data", bus.wr_data, 16'h0077);
    exp_w[0] = 16'h0066;
    exp_w[1] = 16'h0077;
`endif
    wait_rv("edge");
    end_read("edge");
    check_burst("edge", PK ? 1 : 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_wr_ctrl.md
Name: uart_wr_ctrl

Overview:
Write-side controller between uart_rx and the SDRAM write FIFO. It gathers received UART bytes into 16-bit words and issues wr_fifo write requests until a fixed-length SDRAM burst is full. A short or idle burst is padded with zero words. After a settle delay it asserts read_valid, holding it until the read FIFO holds a full burst, then re-arms for the next burst.

Parameters:
BURST_NUM, 10, words per SDRAM burst; range 1..1023.
IDLE_TIMEOUT, 52080, clk_50m cycles with no rx_flag before a partial burst is flushed (about one 9600-baud character).
WAIT_CYC, 750, clk_50m cycles between the last write and read_valid assertion.

Ports:
clk_50m  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-low
rx_data  in  8  received byte, valid when rx_flag=1
rx_flag  in  1  one-cycle strobe from uart_rx
rd_fifo_num  in  10  read-FIFO fill level, in words
wr_req  out  1  one-cycle write strobe to the write FIFO
wr_data  out  16  write word, valid with wr_req
read_valid  out  1  read-burst enable to the SDRAM FIFO controller
busy  out  1  high in S_PAD, S_WAIT and S_READ
ovf  out  1  sticky flag: a byte was dropped

Behaviour:
Reset (async): state=S_IDLE, wr_req=0, wr_data=0, read_valid=0, busy=0, ovf=0, word_cnt=0, idle_cnt=0, wait_cnt=0, half_valid=0.

State machine:
- S_IDLE: on rx_flag, go to S_COLLECT and handle the byte as in S_COLLECT.
- S_COLLECT:
  - Each accepted byte produces a word (see packing rules).
  - wr_req is registered and pulses exactly 1 cycle after the rx_flag that completes a word. word_cnt increments on each wr_req.
  - idle_cnt clears on rx_flag and otherwise increments.
  - When idle_cnt==IDLE_TIMEOUT-1 with no rx_flag that cycle, go to S_PAD.
  - If rx_flag and expiry coincide, rx_flag wins: idle_cnt clears and there is no flush.
  - The cycle after the wr_req that makes word_cnt==BURST_NUM, go to S_WAIT.
- S_PAD:
  - If a half word is pending, first write {8'h00, held byte}.
  - Then write 16'h0000, one wr_req per cycle (back-to-back), until word_cnt==BURST_NUM.
  - Then go to S_WAIT.
- S_WAIT: wait_cnt counts 0..WAIT_CYC-1. At terminal count, clear wait_cnt, set read_valid=1 and go to S_READ.
- S_READ:
  - read_valid stays 1 until rd_fifo_num>=BURST_NUM.
  - The next cycle: read_valid=0, word_cnt=0, idle_cnt=0, go to S_IDLE.
- rx_flag in S_PAD, S_WAIT or S_READ: the byte is dropped and ovf sets. ovf clears only on reset.
- No wr_req is ever issued outside S_COLLECT and S_PAD. word_cnt never exceeds BURST_NUM.
- Reset mid-burst: everything returns to reset values immediately. Partial words are discarded and no pad writes are issued.
- Counter widths: word_cnt 10 bits, idle_cnt 17 bits, wait_cnt 16 bits. All counters are unsigned with no wrap in legal operation.

Optional Feature:
Macro UART_WR_BYTE_PACK_EN.
- Undefined: one word per byte. wr_data={8'h00, rx_data}, half_valid is always 0, and BURST_NUM counts bytes.
- Defined: two bytes per word, little-endian.
  - First byte is held (half_valid=1).
  - Second byte completes the word: wr_data={rx_data, held}, and half_valid clears.
  - On timeout with half_valid=1, S_PAD writes the held byte zero-extended as its first word.

Test Plan:
1. Unpacked, BURST_NUM=10: send bytes 0x01..0x0A at 9600 baud -> 10 wr_req with wr_data 0x0001..0x000A; S_WAIT for 750 cycles; read_valid=1. Force rd_fifo_num=10 -> read_valid=0 one cycle later, state S_IDLE.
2. Unpacked: send 4 bytes 0xA1..0xA4, then idle -> 52080 cycles after the last rx_flag, 6 consecutive wr_req of 0x0000; total 10 writes; read_valid 750 cycles later.
3. Packed: send 0x11, 0x22, 0x33, then idle -> writes 0x2211, 0x0033, then 8×0x0000.
4. After burst completion, pulse rx_flag during S_WAIT with 0x55 -> no wr_req, ovf=1 and stays 1 through S_IDLE.
5. Assert rst_n low for 1 cycle after 5 bytes of a burst -> all outputs 0 immediately, no pad writes. A new 10-byte burst then completes normally.
6. Issue rx_flag in the exact cycle idle_cnt==IDLE_TIMEOUT-1 -> no pad and no state change to S_PAD. The byte is written (wr_req 1 cycle later) and idle_cnt restarts at 0.
